// File: rtl/ibex_rf_write_sched.sv
// Register-file write-port scheduler: sweeps registers 1..NUM_WORDS-1 to WordZeroVal after
// reset or scrub, then round-robins two writeback requesters onto the single registered write port.
module ibex_rf_write_sched #(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      scrub_req_i,
  input  logic [1:0]                req_valid_i,
  output logic [1:0]                req_ready_o,
  input  logic [1:0][4:0]           req_waddr_i,
  input  logic [1:0][DataWidth-1:0] req_wdata_i,
  output logic                      rf_we_o,
  output logic [4:0]                rf_waddr_o,
  output logic [DataWidth-1:0]      rf_wdata_o,
  output logic                      init_done_o,
  output logic                      illegal_addr_o
);

  localparam logic [4:0] LastAddr = RV32E ? 5'd15 : 5'd31;
  localparam logic [0:0] StSweep  = 1'b0;
  localparam logic [0:0] StRun    = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 lg_q, lg_d;
  logic                 we_q, we_d;
  logic [4:0]           waddr_q, waddr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic                 done_q, done_d;
  logic                 ill_q, ill_d;

  logic       gnt_vld;
  logic       gnt_idx;
  logic       serve;
  logic [4:0] sweep_addr;
  logic [4:0] gnt_addr;
  logic       oob;

  // When both requesters are valid the one not granted last time wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 1'b0;
    case (req_valid_i)
      2'b01:   begin gnt_vld = 1'b1; gnt_idx = 1'b0;   end
      2'b10:   begin gnt_vld = 1'b1; gnt_idx = 1'b1;   end
      2'b11:   begin gnt_vld = 1'b1; gnt_idx = ~lg_q;  end
      default: begin gnt_vld = 1'b0; gnt_idx = 1'b0;   end
    endcase
  end

  assign serve       = (state_q == StRun) && !scrub_req_i;
  assign req_ready_o = (serve && gnt_vld) ? (2'b01 << gnt_idx) : 2'b00;
  assign gnt_addr    = req_waddr_i[gnt_idx];
  assign oob         = RV32E && gnt_addr[4];
  assign sweep_addr  = scrub_req_i ? 5'd1 : cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lg_d    = lg_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    ill_d   = 1'b0;
    case (state_q)
      StSweep: begin
        we_d    = 1'b1;
        waddr_d = sweep_addr;
        wdata_d = WordZeroVal;
        cnt_d   = sweep_addr + 5'd1;
        if (sweep_addr == LastAddr) begin
          state_d = StRun;
          done_d  = 1'b1;
        end
      end
      default: begin
        if (scrub_req_i) begin
          state_d = StSweep;
          cnt_d   = 5'd1;
          done_d  = 1'b0;
        end else if (gnt_vld) begin
          // Dropped writes (x0, out of range) still update the address/data registers.
          lg_d    = gnt_idx;
          waddr_d = gnt_addr;
          wdata_d = req_wdata_i[gnt_idx];
          we_d    = (gnt_addr != 5'd0) && !oob;
          ill_d   = oob;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StSweep;
      cnt_q   <= 5'd1;
      lg_q    <= 1'b1;
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= WordZeroVal;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lg_q    <= lg_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
    end
  end

  assign rf_we_o        = we_q;
  assign rf_waddr_o     = waddr_q;
  assign rf_wdata_o     = wdata_q;
  assign init_done_o    = done_q;
  assign illegal_addr_o = ill_q;

endmodule
